// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
// Saturating build is selected with the PROD_ACCUM_SAT_EN macro (see acc_add).
package prod_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_PW        = 8;
  localparam int DEF_AW        = 12;
  localparam int DEF_MAX_TERMS = 16;

endpackage

// File: rtl/acc_add.sv
// Combinational accumulate step: acc + zero-extended prod, with carry out.
// Build option PROD_ACCUM_SAT_EN clamps the sum to all-ones on carry.
module acc_add
  import prod_accum_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] full;

  always_comb begin
    full  = {1'b0, acc} + (AW + 1)'(prod);
    carry = full[AW];
`ifdef PROD_ACCUM_SAT_EN
    // Once clamped, a further non-zero add carries again and stays clamped.
    sum = carry ? {AW{1'b1}} : full[AW-1:0];
`else
    sum = full[AW-1:0];
`endif
  end

endmodule

// File: rtl/prod_accum.sv
// Packet accumulator for multiplier products: sums beats until in_last or
// MAX_TERMS, then holds the result until the consumer takes it.
// Handshake: a beat transfers on in_valid & in_ready; a result transfers on
// out_valid & out_ready. Both ready/valid outputs are registered from state.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter  int PW        = DEF_PW,
  parameter  int AW        = DEF_AW,
  parameter  int MAX_TERMS = DEF_MAX_TERMS,
  localparam int CW        = $clog2(MAX_TERMS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic [AW-1:0] add_sum;
  logic          add_carry;
  logic          accept;

  assign accept = in_valid & in_ready;

  acc_add #(
    .PW(PW),
    .AW(AW)
  ) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (add_sum),
    .carry(add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc <= AW'(in_prod);
            cnt <= CW'(1);
            ovf <= 1'b0;
            if (in_last || (MAX_TERMS == 1)) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt + CW'(1);
            ovf <= ovf | add_carry;
            if (in_last || ((cnt + CW'(1)) == MAX_CNT)) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // The result register is also the accumulator, so it clears on hand-off.
          if (out_ready) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: packet-level model with expected-result
// queue compared every cycle, plus literal checks of the directed scenarios.
module tb_prod_accum;

  localparam int PW   = 8;
  localparam int AW   = 12;
  localparam int MAXT = 16;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam int W    = AW + CW + 1;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prod = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  // Narrow-accumulator instance for the overflow scenario
  logic          v8 = 1'b0;
  logic          rdy8;
  logic [PW-1:0] p8 = '0;
  logic          l8 = 1'b0;
  logic          ov8;
  logic          or8 = 1'b0;
  logic [7:0]    sum8;
  logic [CW-1:0] cnt8;
  logic          ovf8;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  prod_accum #(.PW(PW), .AW(AW), .MAX_TERMS(MAXT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  prod_accum #(.PW(PW), .AW(8), .MAX_TERMS(MAXT)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .in_prod(p8), .in_last(l8), .out_valid(ov8),
    .out_ready(or8), .out_sum(sum8), .out_count(cnt8),
    .out_ovf(ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           m_terms[$];
  bit           m_hold = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_terms.delete();
      exp_q.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        if (exp_q.size() > 0) exp_q.delete(0);
      end
    end else if (in_valid) begin
      m_terms.push_back(int'(in_prod));
      if (in_last || m_terms.size() == MAXT) begin
        int s;
        bit o;
        s = 0;
        o = 1'b0;
        foreach (m_terms[i]) begin
          s += m_terms[i];
          if (s > AMAX) begin
            o = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
            s = AMAX;
`else
            s -= AMAX + 1;
`endif
          end
        end
        exp_q.push_back({o, CW'(m_terms.size()), AW'(s)});
        m_terms.delete();
        m_hold = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 0, 1);
        end else begin
          logic [W-1:0] e;
          e = exp_q[0];
          chk("out_sum", int'(out_sum), int'(e[AW-1:0]));
          chk("out_count", int'(out_count), int'(e[AW+CW-1:AW]));
          chk("out_ovf", int'(out_ovf), int'(e[W-1]));
        end
      end
    end
  end

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic send(input int p, input bit l);
    int k;
    in_valid = 1'b1;
    in_prod  = PW'(p);
    in_last  = l;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("send_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    // single beat closes the packet
    send(225, 1'b1);
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_sum", int'(out_sum), 225);
    chk("s1_count", int'(out_count), 1);
    chk("s1_ovf", int'(out_ovf), 0);
    take();
    chk("s1_ready_after", int'(in_ready), 1);

    // forced close at MAX_TERMS
    for (int i = 0; i < 16; i++) send(225, 1'b0);
    chk("s2_valid", int'(out_valid), 1);
    chk("s2_sum", int'(out_sum), 3600);
    chk("s2_count", int'(out_count), 16);
    chk("s2_ovf", int'(out_ovf), 0);
    chk("s2_ready_hold", int'(in_ready), 0);
    take();

    // narrow accumulator overflow: 200 + 100 in 8 bits
    v8 = 1'b1; p8 = 8'd200; l8 = 1'b0;
    @(negedge clk);
    p8 = 8'd100; l8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0; l8 = 1'b0;
    chk("s3_valid", int'(ov8), 1);
`ifdef PROD_ACCUM_SAT_EN
    chk("s3_sum", int'(sum8), 255);
`else
    chk("s3_sum", int'(sum8), 44);
`endif
    chk("s3_count", int'(cnt8), 2);
    chk("s3_ovf", int'(ovf8), 1);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("s3_idle", int'(ov8), 0);

    // gaps between beats, consumer stalls 5 cycles with input pressure
    send(3, 1'b0);
    idle(2);
    send(5, 1'b0);
    idle(3);
    send(7, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("s4_valid", int'(out_valid), 1);
      chk("s4_sum", int'(out_sum), 15);
      chk("s4_count", int'(out_count), 3);
      chk("s4_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    take();
    in_valid = 1'b0;
    chk("s4_sum_cleared", int'(out_sum), 0);
    idle(1);

    // reset mid-packet discards the partial sum
    send(9, 1'b0);
    send(9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s5_valid_rst", int'(out_valid), 0);
    chk("s5_sum_rst", int'(out_sum), 0);
    chk("s5_count_rst", int'(out_count), 0);
    rst_n = 1'b1;
    idle(1);
    send(4, 1'b1);
    chk("s5_sum", int'(out_sum), 4);
    chk("s5_count", int'(out_count), 1);
    take();

    // zero products count; input held valid during HOLD waits a bubble
    send(10, 1'b0);
    send(0, 1'b0);
    send(0, 1'b1);
    chk("s6_sum", int'(out_sum), 10);
    chk("s6_count", int'(out_count), 3);
    in_valid = 1'b1;
    in_prod  = 8'd50;
    in_last  = 1'b1;
    idle(2);
    chk("s6_ready_hold", int'(in_ready), 0);
    take();
    chk("s6_bubble_valid", int'(out_valid), 0);
    chk("s6_bubble_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("s6_next_valid", int'(out_valid), 1);
    chk("s6_next_sum", int'(out_sum), 50);
    chk("s6_next_count", int'(out_count), 1);
    take();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
